demux_1_to_2_reg: RTL and testbench
===================================

Name: demux_1_to_2_reg

Overview:
- Registered 1-to-2 demultiplexer for the DE0 Cycloneᴵᴵᴵ workshop board. It is the inverse of the 2-to-1 select lab.
- A 3-bit value on the switches is routed to one of two held output registers, X or Y. SW[9] chooses the destination, and a debounced KEY press commits the write.
- Both registers and the live input are shown on the red LEDs.
- Top-level board module; it sits directly on the board pins.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples needed to accept a KEY level change (10 ms at 50 MHz). Minimum 2.
- DATA_W, 3, width of the demux data path and of each output register.

Ports:
- CLOCK_50  input  1  50 MHz board clock. Single clock domain.
- RESET  input  1  asynchronous, active-high reset.
- SW  input  10  slide switches:
  - SW[2:0] is the data in.
  - SW[9] is the select: 0 routes to X, 1 routes to Y.
  - SW[8:3] are unused.
- KEY  input  2  raw pushbuttons, active-low when pressed:
  - KEY[0] is load.
  - KEY[1] is clear.
- LEDR  output  10  LED map:
  - LEDR[2:0] = X register.
  - LEDR[5:3] = Y register.
  - LEDR[8:6] = synchronized live data in.
  - LEDR[9] = synchronized select.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - X=0, Y=0.
  - All synchronizer flops = 0 for SW and 1 for KEY.
  - Debounced KEY state = 1 (released).
  - Debounce counters = 0.
  - LEDR = 0x000.
- Input synchronization:
  - SW[9] and SW[2:0] each pass through a 2-FF synchronizer.
  - KEY[1:0] each pass through a 2-FF synchronizer.
  - LEDR[9] and LEDR[8:6] show the synchronized SW values, 2-3 clocks after a switch moves.
- Debounce, per KEY:
  - The counter increments while the synchronized level differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event:
  - Registered 1-cycle pulse on the debounced 1->0 transition only.
  - Release (0->1) generates nothing.
  - Holding a key produces exactly one pulse.
- Load pulse: on the next clock, the synchronized SW[2:0] is written into X if the synchronized SW[9]=0, else into Y. The other register holds.
- Clear pulse: X and Y both go to 0 on the next clock.
- Load and clear pulses in the same cycle: clear wins, and the load is discarded.
- Latency:
  - A clean raw press is visible on the LEDs DEBOUNCE_CYCLES+4 clocks after the first clock edge that samples it (±1 clock for async sampling phase).
  - Data and select are those held by the synchronizers in the pulse cycle.
- Select toggled during debounce: the value at the pulse cycle decides the destination.
- RESET asserted mid-debounce or mid-pulse: immediate return to reset values, with no pending write.
- While reset is held: no pulse.
- After release: a key still held does not produce a press pulse, because the debounced state starts released and must see a transition.
  - Correction, to be implemented exactly so: a key held through reset release debounces to pressed after DEBOUNCE_CYCLES and then produces one pulse.
- Registers are never written except by load, clear or reset.

Decomposition:
- Package demux_lab_pkg:
  - DATA_W.
  - LED field index constants: X_LSB=0, Y_LSB=3, LIVE_LSB=6, SEL_BIT=9.
  - KEY index constants: KEY_LOAD=0, KEY_CLEAR=1.
- One sub-module, key_debounce:
  - Parameter DEBOUNCE_CYCLES.
  - Ports: clock, reset, raw_n, press_pulse, level.
  - Contains the 2-FF synchronizer, counter and edge detector.
  - Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4 in sim):
- Reset: RESET=1 with SW=0x3FF and KEY=0b00 -> LEDR=0x000 during reset. After RESET=0: LEDR[9]=1 and LEDR[8:6]=7 within 3 clocks, while X and Y stay 0 until debounce completes.
- Route to X, then Y:
  - SW[9]=0, SW[2:0]=5, clean KEY[0] press -> LEDR[2:0]=5 at 8±1 clocks; Y unchanged.
  - Then SW[9]=1, SW[2:0]=3, press -> LEDR[5:3]=3 and X still 5; LEDR=0x21D + live bits.
- Bounce: KEY[0] toggles low/high every 2 clocks for 20 clocks, then releases -> no write.
  - Bouncing for 10 clocks and then held low -> exactly one write.
- Hold: KEY[0] held low for 100 clocks while SW[2:0] changes 1->6 -> single write at the pulse cycle only; register keeps the first captured value.
- Clear vs load: KEY[0] and KEY[1] pressed on the same clock with X=5, Y=3 -> X=0, Y=0, and no load.
- Reset mid-debounce: press KEY[0], assert RESET 2 clocks later for 1 clock, release KEY before completion -> X, Y stay 0 and no pulse is ever seen.

Source files
------------

// File: rtl/demux_lab_pkg.sv
// Shared constants for the registered 1-to-2 demux lab: data width,
// LED field positions and pushbutton indices.
package demux_lab_pkg;

  localparam int DATA_W = 3;

  localparam int X_LSB    = 0;
  localparam int Y_LSB    = 3;
  localparam int LIVE_LSB = 6;
  localparam int SEL_BIT  = 9;

  localparam int KEY_LOAD  = 0;
  localparam int KEY_CLEAR = 1;

  typedef enum logic {
    DEST_X = 1'b0,
    DEST_Y = 1'b1
  } dest_e;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, stable-sample debounce counter and a
// registered single-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic press_pulse,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             level_dly;

  // Counter only advances while the synchronized key disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      cnt         <= '0;
      level       <= 1'b1;
      level_dly   <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], raw_n};
      level_dly   <= level;
      press_pulse <= level_dly & ~level;
      if (sync_q[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/demux_1_to_2_reg.sv
// Board top: routes the switch value into held register X or Y on a
// debounced KEY[0] press, KEY[1] clears both; everything shown on LEDR.
module demux_1_to_2_reg #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DATA_W          = demux_lab_pkg::DATA_W
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] LEDR
);

  import demux_lab_pkg::*;

  logic [1:0]        rst_pipe;
  logic              rst_int;
  logic [DATA_W-1:0] data_meta, data_sync;
  logic              sel_meta, sel_sync;
  logic [DATA_W-1:0] x_reg, y_reg;
  logic              load_pulse, clear_pulse;
  logic              load_level, clear_level;
  logic              unused_ok;
  dest_e             dest;

  // Internal reset asserts immediately but releases on a clock edge.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  // Switch synchronizers run off the raw reset so the live LEDs track the
  // switches as soon as RESET drops.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      data_meta <= '0;
      data_sync <= '0;
      sel_meta  <= 1'b0;
      sel_sync  <= 1'b0;
    end else begin
      data_meta <= SW[DATA_W-1:0];
      data_sync <= data_meta;
      sel_meta  <= SW[SEL_BIT];
      sel_sync  <= sel_meta;
    end
  end

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
    .clock       (CLOCK_50),
    .reset       (rst_int),
    .raw_n       (KEY[KEY_LOAD]),
    .press_pulse (load_pulse),
    .level       (load_level)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clock       (CLOCK_50),
    .reset       (rst_int),
    .raw_n       (KEY[KEY_CLEAR]),
    .press_pulse (clear_pulse),
    .level       (clear_level)
  );

  assign dest = dest_e'(sel_sync);

  // Clear has priority; a simultaneous load is dropped.
  always_ff @(posedge CLOCK_50 or posedge rst_int) begin
    if (rst_int) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clear_pulse) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (load_pulse) begin
      if (dest == DEST_X) x_reg <= data_sync;
      else                y_reg <= data_sync;
    end
  end

  always_comb begin
    LEDR                      = '0;
    LEDR[X_LSB +: DATA_W]     = x_reg;
    LEDR[Y_LSB +: DATA_W]     = y_reg;
    LEDR[LIVE_LSB +: DATA_W]  = data_sync;
    LEDR[SEL_BIT]             = sel_sync;
  end

  assign unused_ok = ^{SW[8:3], load_level, clear_level};

endmodule

// File: tb/tb_demux_1_to_2_reg.sv
// Directed bench for demux_1_to_2_reg with a 4-cycle debounce window;
// expected LED words are hand-computed for each step.
module tb_demux_1_to_2_reg;

  logic       clock;
  logic       reset;
  logic [9:0] sw;
  logic [1:0] key;
  logic [9:0] ledr;
  int         checks;
  int         failures;

  demux_1_to_2_reg #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clock),
    .RESET    (reset),
    .SW       (sw),
    .KEY      (key),
    .LEDR     (ledr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [9:0] swVal, input logic [1:0] keyVal, input int cycles);
    sw  = swVal;
    key = keyVal;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    checks++;
    assert (ledr === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%03h expected=0x%03h", tag, ledr, expected);
    end
  endtask

  // Presses one key and counts clocks until the target LED field shows the value.
  task automatic pressAndTime(input string tag, input int keyIdx, input int lsb,
                              input logic [2:0] want, input logic [9:0] finalLed);
    int n;
    n = 0;
    key[keyIdx] = 1'b0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ledr[lsb +: 3] === want) n = i;
    end
    checks++;
    assert (n >= 7 && n <= 9)
    else begin
      failures++;
      $error("[TB] FAIL %s_latency observed=%0d required=7..9", tag, n);
    end
    checkOutput(tag, finalLed);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    sw       = 10'h3FF;
    key      = 2'b00;

    repeat (3) tick();
    checkOutput("reset_hold", 10'h000);

    reset = 1'b0;
    repeat (3) tick();
    checkOutput("live_after_reset", 10'h3C0);
    repeat (12) tick();
    checkOutput("held_keys_no_write", 10'h3C0);

    applyStimulus(10'h005, 2'b11, 10);
    checkOutput("idle_x5", 10'h140);

    pressAndTime("load_x", 0, 0, 3'd5, 10'h145);
    applyStimulus(10'h203, 2'b11, 10);
    checkOutput("release_no_write", 10'h2C5);

    pressAndTime("load_y", 0, 3, 3'd3, 10'h2DD);
    applyStimulus(10'h007, 2'b11, 10);
    checkOutput("pre_bounce", 10'h1DD);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'h007, 2'b10, 2);
      applyStimulus(10'h007, 2'b11, 2);
    end
    applyStimulus(10'h007, 2'b11, 10);
    checkOutput("bounce_no_write", 10'h1DD);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(10'h007, 2'b10, 2);
      applyStimulus(10'h007, 2'b11, 2);
    end
    applyStimulus(10'h007, 2'b10, 20);
    checkOutput("bounce_then_hold", 10'h1DF);
    applyStimulus(10'h002, 2'b10, 20);
    checkOutput("bounce_single_write", 10'h09F);

    applyStimulus(10'h001, 2'b11, 12);
    applyStimulus(10'h001, 2'b10, 12);
    checkOutput("hold_capture", 10'h059);
    applyStimulus(10'h006, 2'b10, 88);
    checkOutput("hold_keeps_first", 10'h199);

    applyStimulus(10'h005, 2'b11, 12);
    pressAndTime("reload_x5", 0, 0, 3'd5, 10'h15D);
    applyStimulus(10'h005, 2'b11, 10);

    applyStimulus(10'h005, 2'b00, 20);
    checkOutput("clear_wins", 10'h140);
    applyStimulus(10'h007, 2'b11, 12);
    checkOutput("pre_reset_test", 10'h1C0);

    applyStimulus(10'h007, 2'b10, 2);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 10'h000);
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(10'h007, 2'b11, 20);
    checkOutput("no_pending_write", 10'h1C0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
